coherent_average_ctrl: RTL and testbench

Sequencer for the coherent-averaging datapath. It arms on a host start command and aligns each frame of M ADC samples to a rising edge of the excitation trigger. It forwards exactly M samples per frame to the averager for `n_frames` frames, then waits for readout to finish. It then sweeps the accumulator clear port over all M bins and reports completion, so the averager never sees partial or misaligned frames.

---
 rtl/coherent_average_pkg.sv | 16 +
 rtl/coherent_average_ctrl_trig_edge_det.sv | 21 ++
 rtl/coherent_average_ctrl.sv | 152 +++++++++++++++
 tb/tb_coherent_average_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherent_average_pkg.sv
// Shared types and default sizing for the coherent-averaging sequencer.
package coherent_average_pkg;

  localparam int M_DEFAULT  = 32;
  localparam int AW_DEFAULT = 16;
  localparam int ADC_W      = 12;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ACQ,
    READOUT,
    CLEAR
  } state_t;

endpackage

// File: rtl/coherent_average_ctrl_trig_edge_det.sv
// Registers the excitation trigger and emits a one-cycle pulse on its rising edge.
module trig_edge_det (
  input  logic clk_rapido,
  input  logic reset,
  input  logic trig,
  output logic trig_rise
);

  logic trig_q;

  always_ff @(posedge clk_rapido) begin
    if (reset) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig;
    end
  end

  assign trig_rise = trig & ~trig_q;

endmodule

// File: rtl/coherent_average_ctrl.sv
// Coherent-averaging sequencer: trigger-aligned M-sample frames, readout wait, accumulator clear.
// Optional trigger-wait timeout is enabled by defining CA_TRIG_TIMEOUT_EN.
module coherent_average_ctrl
  import coherent_average_pkg::*;
#(
  parameter int M  = M_DEFAULT,
  parameter int AW = AW_DEFAULT
`ifdef CA_TRIG_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 1000000
`endif
) (
  input  logic             clk_rapido,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [AW-1:0]    n_frames,
  input  logic             trig,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic [ADC_W-1:0] x,
  output logic             x_valid,
  input  logic             rd_done,
  output logic [AW-1:0]    clr_addr,
  output logic             clr_we,
  output logic             busy,
  output logic             done,
  output logic             overrun
`ifdef CA_TRIG_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam logic [AW-1:0] LAST = AW'(M - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] sample_cnt;
  logic [AW-1:0] frame_cnt;
  logic [AW-1:0] n_lat;
  logic          trig_edge;
  logic          frame_end;
  logic          last_frame;

  trig_edge_det u_trig_edge_det (
    .clk_rapido(clk_rapido),
    .reset     (reset),
    .trig      (trig),
    .trig_rise (trig_edge)
  );

  assign frame_end  = (state_q == ACQ) && adc_valid && (sample_cnt == LAST);
  assign last_frame = (frame_cnt + AW'(1)) == n_lat;

`ifdef CA_TRIG_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  assign tmo_hit = (state_q == ARM) && !trig_edge && (tmo_cnt == 32'(TIMEOUT - 1));
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    clr_we  = (state_q == CLEAR);
    done    = (state_q == CLEAR) && (clr_addr == LAST) && !abort;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = ARM;
        ARM: begin
          if (trig_edge) state_d = ACQ;
`ifdef CA_TRIG_TIMEOUT_EN
          else if (tmo_hit) state_d = IDLE;
`endif
        end
        ACQ:     if (frame_end) state_d = last_frame ? READOUT : ARM;
        READOUT: if (rd_done) state_d = CLEAR;
        CLEAR:   if (clr_addr == LAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_rapido) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_rapido) begin
    if (reset) begin
      x          <= '0;
      x_valid    <= 1'b0;
      clr_addr   <= '0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
      frame_cnt  <= '0;
      n_lat      <= '0;
`ifdef CA_TRIG_TIMEOUT_EN
      timeout    <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      x_valid <= 1'b0;
`ifdef CA_TRIG_TIMEOUT_EN
      // Counting only while in ARM makes every entry into ARM start from zero.
      tmo_cnt <= (state_q == ARM) ? tmo_cnt + 32'd1 : '0;
`endif
      if (abort) begin
        clr_addr <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              n_lat     <= (n_frames == '0) ? AW'(1) : n_frames;
              overrun   <= 1'b0;
              frame_cnt <= '0;
`ifdef CA_TRIG_TIMEOUT_EN
              timeout   <= 1'b0;
`endif
            end
          end
          ARM: begin
            if (trig_edge) sample_cnt <= '0;
`ifdef CA_TRIG_TIMEOUT_EN
            if (tmo_hit) timeout <= 1'b1;
`endif
          end
          ACQ: begin
            if (adc_valid) begin
              x          <= adc_data;
              x_valid    <= 1'b1;
              sample_cnt <= sample_cnt + AW'(1);
            end
            if (frame_end) frame_cnt <= frame_cnt + AW'(1);
            // An edge landing on the frame's final sample belongs to the next ARM window.
            if (trig_edge && !frame_end) overrun <= 1'b1;
          end
          READOUT: if (rd_done) clr_addr <= '0;
          CLEAR:   clr_addr <= (clr_addr == LAST) ? '0 : clr_addr + AW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coherent_average_ctrl.sv
// Self-checking bench for coherent_average_ctrl (M=4): vector table, directed sequences, random traces.
module tb_coherent_average_ctrl;

  localparam int M    = 4;
  localparam int AW   = 16;
  localparam int MAXL = 128;

  logic          clk_rapido = 1'b0;
  logic          reset, start, abort, trig, adc_valid, rd_done;
  logic [AW-1:0] n_frames;
  logic [11:0]   adc_data;
  logic [11:0]   x;
  logic          x_valid, clr_we, busy, done, overrun;
  logic [AW-1:0] clr_addr;
`ifdef CA_TRIG_TIMEOUT_EN
  logic          timeout;
`endif

  int checks = 0;
  int errors = 0;

  logic        trig_a [MAXL];
  logic        valid_a[MAXL];
  logic [11:0] data_a [MAXL];
  logic [11:0] exp_q[$];

  always #5 clk_rapido = ~clk_rapido;

  coherent_average_ctrl #(
    .M (M),
    .AW(AW)
`ifdef CA_TRIG_TIMEOUT_EN
    ,
    .TIMEOUT(50)
`endif
  ) dut (
    .clk_rapido(clk_rapido),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .n_frames  (n_frames),
    .trig      (trig),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .x         (x),
    .x_valid   (x_valid),
    .rd_done   (rd_done),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
`ifdef CA_TRIG_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  typedef struct {
    logic          s, t, v, r;
    logic [AW-1:0] n;
    logic [11:0]   d;
    logic          xv;
    logic [11:0]   xd;
    logic          b, dn, cw;
    logic [AW-1:0] a;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic s, t, v, r, input logic [AW-1:0] n,
                              input logic [11:0] d, input logic xv, input logic [11:0] xd,
                              input logic b, dn, cw, input logic [AW-1:0] a);
    vec_t e;
    e.s = s; e.t = t; e.v = v; e.r = r; e.n = n; e.d = d;
    e.xv = xv; e.xd = xd; e.b = b; e.dn = dn; e.cw = cw; e.a = a;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_rapido);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; trig = 1'b0; adc_valid = 1'b0;
    rd_done = 1'b0; n_frames = '0; adc_data = '0;
  endtask

  task automatic clear_trace();
    for (int k = 0; k < MAXL; k++) begin
      trig_a[k] = 1'b0; valid_a[k] = 1'b0; data_a[k] = '0;
    end
  endtask

  // Trace-level reference: find each trigger edge while armed, take the next M valid samples.
  task automatic model(input int n, input int len, output int frames, output logic ov);
    int eff, pos, i, j, cnt;
    eff = (n == 0) ? 1 : n;
    exp_q.delete();
    frames = 0; ov = 1'b0; pos = 1;
    while (frames < eff) begin
      i = pos;
      while (i < len && !(trig_a[i] && !trig_a[i-1])) i++;
      if (i >= len) break;
      cnt = 0; j = i + 1;
      while (cnt < M && j < len) begin
        if (trig_a[j] && !trig_a[j-1] && !(valid_a[j] && cnt == M - 1)) ov = 1'b1;
        if (valid_a[j]) begin
          exp_q.push_back(data_a[j]);
          cnt++;
        end
        j++;
      end
      if (cnt < M) break;
      frames++;
      pos = j;
    end
  endtask

  task automatic run_trace(input string tag, input int n, input int len,
                           output bit complete, output int ngot, output logic ov);
    int          frames;
    logic [11:0] got_q[$];
    model(n, len, frames, ov);
    for (int k = 0; k < len; k++) begin
      start     = (k == 0) ? 1'b1 : ($urandom_range(7) == 0);
      n_frames  = (k == 0) ? AW'(n) : AW'($urandom);
      trig      = trig_a[k];
      adc_valid = valid_a[k];
      adc_data  = data_a[k];
      tick();
      if (x_valid) got_q.push_back(x);
    end
    idle_inputs();
    ngot = got_q.size();
    check({tag, ".count"}, ngot, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < ngot; k++)
      check($sformatf("%s.x[%0d]", tag, k), got_q[k], exp_q[k]);
    check({tag, ".overrun"}, overrun, ov);
    check({tag, ".busy"}, busy, 1);
    complete = (frames == ((n == 0) ? 1 : n));
  endtask

  task automatic finish_run(input string tag);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    for (int a = 0; a < M; a++) begin
      if (a > 0) tick();
      check($sformatf("%s.clr_we[%0d]", tag, a), clr_we, 1);
      check($sformatf("%s.clr_addr[%0d]", tag, a), clr_addr, a);
      check($sformatf("%s.done[%0d]", tag, a), done, (a == M - 1));
    end
    tick();
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".done_end"}, done, 0);
    check({tag, ".clr_we_end"}, clr_we, 0);
  endtask

  task automatic abort_run(input string tag);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check({tag, ".abort_busy"}, busy, 0);
    check({tag, ".abort_xv"}, x_valid, 0);
  endtask

  initial begin
    bit   complete;
    int   ngot, k;
    logic ov;

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst.x", x, 0);
    check("rst.x_valid", x_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.clr_we", clr_we, 0);
    check("rst.clr_addr", clr_addr, 0);
    check("rst.overrun", overrun, 0);
`ifdef CA_TRIG_TIMEOUT_EN
    check("rst.timeout", timeout, 0);
`endif
    reset = 1'b0;
    tick();

    // n_frames=0 run with gapped adc_valid, ignored start/rd_done, clear sweep, done pulse.
    //             s  t  v  r  n  d        xv xd       b  dn cw a
    tbl[0]  = mk(1, 0, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 12'h111, 0, 12'h000, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 12'hA01, 1, 12'hA01, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 12'hBAD, 0, 12'hA01, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 1, 0, 7, 12'hA02, 1, 12'hA02, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 12'hBAD, 0, 12'hA02, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 12'hA03, 1, 12'hA03, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 12'hA04, 1, 12'hA04, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 12'h555, 0, 12'hA04, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 12'h000, 0, 12'hA04, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 12'h000, 0, 12'hA04, 1, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 12'h000, 0, 12'hA04, 1, 0, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 12'h000, 0, 12'hA04, 1, 0, 1, 2);
    tbl[14] = mk(0, 0, 0, 0, 0, 12'h000, 0, 12'hA04, 1, 1, 1, 3);
    tbl[15] = mk(0, 0, 0, 0, 0, 12'h000, 0, 12'hA04, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 0, 12'h000, 0, 12'hA04, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].s; trig = tbl[i].t; adc_valid = tbl[i].v; rd_done = tbl[i].r;
      n_frames = tbl[i].n; adc_data = tbl[i].d;
      tick();
      check($sformatf("tbl[%0d].x_valid", i), x_valid, tbl[i].xv);
      check($sformatf("tbl[%0d].x", i), x, tbl[i].xd);
      check($sformatf("tbl[%0d].busy", i), busy, tbl[i].b);
      check($sformatf("tbl[%0d].done", i), done, tbl[i].dn);
      check($sformatf("tbl[%0d].clr_we", i), clr_we, tbl[i].cw);
      check($sformatf("tbl[%0d].clr_addr", i), clr_addr, tbl[i].a);
      check($sformatf("tbl[%0d].overrun", i), overrun, 0);
    end
    idle_inputs();
    tick();

    // Two frames, trigger every 10 cycles, adc_valid constant: 8 samples.
    clear_trace();
    for (int i = 0; i < 40; i++) begin
      trig_a[i] = (i % 10 == 2); valid_a[i] = 1'b1; data_a[i] = 12'(i);
    end
    run_trace("two_frames", 2, 40, complete, ngot, ov);
    check("two_frames.n8", ngot, 8);
    check("two_frames.complete", complete, 1);
    if (complete) finish_run("two_frames"); else abort_run("two_frames");

    // n_frames=0 behaves as 1.
    clear_trace();
    for (int i = 0; i < 20; i++) begin
      trig_a[i] = (i == 2); valid_a[i] = 1'b1; data_a[i] = 12'(100 + i);
    end
    run_trace("nf0", 0, 20, complete, ngot, ov);
    check("nf0.n4", ngot, 4);
    if (complete) finish_run("nf0"); else abort_run("nf0");

    // Second edge two samples into the frame: overrun, frame still has 4 samples.
    clear_trace();
    for (int i = 0; i < 20; i++) begin
      trig_a[i] = (i == 2) || (i == 5); valid_a[i] = 1'b1; data_a[i] = 12'(200 + i);
    end
    run_trace("ovr", 1, 20, complete, ngot, ov);
    check("ovr.n4", ngot, 4);
    check("ovr.flag", overrun, 1);
    if (complete) finish_run("ovr"); else abort_run("ovr");

    // Edge on the final sample of frame 1 neither starts frame 2 nor sets overrun.
    clear_trace();
    for (int i = 0; i < 30; i++) begin
      trig_a[i] = (i == 2) || (i == 6) || (i == 12); valid_a[i] = 1'b1; data_a[i] = 12'(300 + i);
    end
    run_trace("coinc", 2, 30, complete, ngot, ov);
    check("coinc.flag", overrun, 0);
    if (complete) finish_run("coinc"); else abort_run("coinc");

    // Abort in ACQ after two samples.
    start = 1'b1; n_frames = 16'd3; tick(); start = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    adc_valid = 1'b1; adc_data = 12'h001; tick();
    adc_data = 12'h002; tick();
    check("abort.xv_before", x_valid, 1);
    abort = 1'b1; adc_data = 12'h003; tick(); abort = 1'b0; adc_valid = 1'b0;
    check("abort.x_valid", x_valid, 0);
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort.idle_done[%0d]", i), done, 0);
    end

    // Reset mid-run clears overrun and everything else.
    start = 1'b1; n_frames = 16'd1; tick(); start = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    adc_valid = 1'b1; adc_data = 12'h0F0; tick();
    trig = 1'b1; tick(); trig = 1'b0;
    check("midrst.overrun_set", overrun, 1);
    reset = 1'b1; tick(); reset = 1'b0; adc_valid = 1'b0;
    check("midrst.x", x, 0);
    check("midrst.x_valid", x_valid, 0);
    check("midrst.busy", busy, 0);
    check("midrst.overrun", overrun, 0);
    check("midrst.clr_addr", clr_addr, 0);
    check("midrst.done", done, 0);
    tick();

`ifdef CA_TRIG_TIMEOUT_EN
    // No trigger: timeout after 50 ARM cycles, back to IDLE without done.
    start = 1'b1; n_frames = 16'd2; tick(); start = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      check($sformatf("tmo.done[%0d]", i), done, 0);
      if (i == 49) begin
        check("tmo.busy_49", busy, 1);
        check("tmo.flag_49", timeout, 0);
      end
    end
    check("tmo.flag", timeout, 1);
    check("tmo.busy", busy, 0);
    tick();
`endif

    // Random traces with mid-run start/n_frames noise.
    for (int r = 0; r < 6; r++) begin
      clear_trace();
      for (int i = 0; i < 90; i++) begin
        valid_a[i] = ($urandom_range(3) != 0);
        data_a[i]  = 12'($urandom);
      end
      k = $urandom_range(2, 5);
      while (k < 90) begin
        int hl;
        hl = $urandom_range(1, 3);
        for (int h = 0; h < hl && k + h < 90; h++) trig_a[k + h] = 1'b1;
        k += hl + $urandom_range(2, 10);
      end
      run_trace($sformatf("rnd%0d", r), $urandom_range(1, 3), 90, complete, ngot, ov);
      if (complete) finish_run($sformatf("rnd%0d", r));
      else abort_run($sformatf("rnd%0d", r));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
